// File: rtl/ps2_key_input_pkg.sv
// Shared scan-code constants, frame FSM encoding and parity helper for the
// PS/2 keyboard receiver.
package ps2_key_input_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_input_line_filter.sv
// Synchronizes both PS/2 lines, deglitches ps2_clk and emits a one-cycle
// pulse when the filtered clock falls.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic data_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0] raw_w;
    logic [1:0] sync_w;

    assign raw_w = {ps2_data_i, ps2_clk_i};

    // Bit 0 is the clock line, bit 1 the data line; both idle high.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_q;
            logic sync_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    meta_q <= 1'b1;
                    sync_q <= 1'b1;
                end else begin
                    meta_q <= raw_w[gi];
                    sync_q <= meta_q;
                end
            end
            assign sync_w[gi] = sync_q;
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             fall_q, fall_d;

    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        fall_d = 1'b0;
        if (sync_w[0] != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync_w[0];
                fall_d = filt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            fall_q <= fall_d;
        end
    end

    assign data_o = sync_w[1];
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_key_input.sv
// PS/2 keyboard receiver: deframes 11-bit frames, tracks E0/F0 prefixes and
// reports scan codes plus held levels for the jump, duck and start keys.
module ps2_key_input
    import ps2_key_input_pkg::*;
#(
    parameter int         FILTER_LEN = 8,
    parameter int         TIMEOUT    = 50000,
    parameter logic [7:0] CODE_JUMP  = SC_SPACE,
    parameter logic [7:0] CODE_UP    = SC_UP,
    parameter logic [7:0] CODE_DOWN  = SC_DOWN,
    parameter logic [7:0] CODE_START = SC_ENTER
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_ext,
    output logic       code_break,
    output logic       code_valid,
    output logic       frame_err,
    output logic       key_up,
    output logic       key_down,
    output logic       key_start
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic data_s;
    logic fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk_i (ps2_clk),
        .ps2_data_i(ps2_data),
        .data_o    (data_s),
        .fall_o    (fall)
    );

    frame_state_e     state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [7:0]       code_q, code_d;
    logic             code_ext_q, code_ext_d;
    logic             code_break_q, code_break_d;
    logic             code_valid_q, code_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             key_up_q, key_up_d;
    logic             key_down_q, key_down_d;
    logic             key_start_q, key_start_d;
    logic             accept;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        code_d       = code_q;
        code_ext_d   = code_ext_q;
        code_break_d = code_break_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        key_up_d     = key_up_q;
        key_down_d   = key_down_q;
        key_start_d  = key_start_q;
        accept       = 1'b0;

        if (state_q == ST_IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    if (data_s && odd_parity_ok(shift_q, parity_q)) begin
                        accept = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
        endcase

        // A stalled frame also drops any half-received prefix sequence.
        if (state_q != ST_IDLE && !fall && tmo_q == TMO_LAST) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
            tmo_d       = '0;
        end

        if (accept) begin
            if (shift_q == SC_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                code_valid_d = 1'b1;
                code_d       = shift_q;
                code_ext_d   = ext_q;
                code_break_d = brk_q;
                ext_d        = 1'b0;
                brk_d        = 1'b0;
                if ((shift_q == CODE_JUMP && !ext_q) || (shift_q == CODE_UP && ext_q)) begin
                    key_up_d = !brk_q;
                end
                if (shift_q == CODE_DOWN && ext_q) begin
                    key_down_d = !brk_q;
                end
                if (shift_q == CODE_START && !ext_q) begin
                    key_start_d = !brk_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            code_q       <= 8'd0;
            code_ext_q   <= 1'b0;
            code_break_q <= 1'b0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            key_up_q     <= 1'b0;
            key_down_q   <= 1'b0;
            key_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            code_q       <= code_d;
            code_ext_q   <= code_ext_d;
            code_break_q <= code_break_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            key_up_q     <= key_up_d;
            key_down_q   <= key_down_d;
            key_start_q  <= key_start_d;
        end
    end

    assign code       = code_q;
    assign code_ext   = code_ext_q;
    assign code_break = code_break_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
    assign key_up     = key_up_q;
    assign key_down   = key_down_q;
    assign key_start  = key_start_q;

endmodule

// File: tb/tb_ps2_key_input.sv
// Directed frames against an event-level model of the keyboard protocol;
// one compare process checks every output cycle.
module tb_ps2_key_input;

    localparam int F    = 8;
    localparam int TMO  = 50000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_ext, code_break, code_valid, frame_err;
    logic       key_up, key_down, key_start;

    ps2_key_input #(.FILTER_LEN(F), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (code),
        .code_ext  (code_ext),
        .code_break(code_break),
        .code_valid(code_valid),
        .frame_err (frame_err),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_start (key_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        int         lo;
        int         hi;
    } ev_t;
    typedef struct {
        int lo;
        int hi;
    } win_t;

    ev_t  ev_q[$];
    win_t err_q[$];
    bit   m_ext = 0, m_brk = 0, m_up = 0, m_down = 0, m_start = 0;
    bit   in_reset = 1;
    int   n_checks = 0, n_fail = 0;
    int   n_valid_seen = 0, n_err_seen = 0;
    int   last_fall = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: what an accepted byte means to the keyboard protocol.
    task automatic model_byte(logic [7:0] b, bit bad, int t);
        ev_t e;
        win_t w;
        if (bad) begin
            w.lo = t + 1; w.hi = t + F + 3;
            err_q.push_back(w);
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            e.code = b; e.ext = m_ext; e.brk = m_brk; e.lo = t + 1; e.hi = t + F + 3;
            ev_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic apply_keys(ev_t e);
        if ((e.code == 8'h29 && !e.ext) || (e.code == 8'h75 && e.ext)) m_up = !e.brk;
        if (e.code == 8'h72 && e.ext) m_down = !e.brk;
        if (e.code == 8'h5A && !e.ext) m_start = !e.brk;
    endtask

    always @(negedge clk) begin
        ev_t  e;
        win_t w;
        if (!in_reset) begin
            if (code_valid) begin
                n_valid_seen++;
                check("code_valid_expected", ev_q.size() > 0, 1);
                if (ev_q.size() > 0) begin
                    e = ev_q.pop_front();
                    check("code_valid_latency", (cyc >= e.lo && cyc <= e.hi), 1);
                    check("code", code, e.code);
                    check("code_ext", code_ext, e.ext);
                    check("code_break", code_break, e.brk);
                    apply_keys(e);
                end
            end
            if (frame_err) begin
                n_err_seen++;
                check("frame_err_expected", err_q.size() > 0, 1);
                if (err_q.size() > 0) begin
                    w = err_q.pop_front();
                    check("frame_err_timing", (cyc >= w.lo && cyc <= w.hi), 1);
                end
            end
            if (ev_q.size() > 0 && cyc > ev_q[0].hi) begin
                check("code_valid_arrived", 0, ev_q.size());
                void'(ev_q.pop_front());
            end
            if (err_q.size() > 0 && cyc > err_q[0].hi) begin
                check("frame_err_arrived", 0, err_q.size());
                void'(err_q.pop_front());
            end
            check("key_up", key_up, m_up);
            check("key_down", key_down, m_down);
            check("key_start", key_start, m_start);
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(bit b, int half);
        ps2_data = b;
        wait_cyc(half);
        ps2_clk = 1'b0;
        last_fall = cyc;
        wait_cyc(half);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] b, bit flip_par, int half);
        bit p;
        p = (~^b) ^ flip_par;
        send_bit(1'b0, half);
        for (int i = 0; i < 8; i++) send_bit(b[i], half);
        send_bit(p, half);
        ps2_data = 1'b1;
        wait_cyc(half);
        ps2_clk = 1'b0;
        model_byte(b, flip_par, cyc);
        wait_cyc(half);
        ps2_clk = 1'b1;
        wait_cyc(half);
    endtask

    task automatic send_partial(logic [7:0] b, int nbits);
        send_bit(1'b0, HALF);
        for (int i = 0; i < nbits; i++) send_bit(b[i], HALF);
        ps2_data = 1'b1;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_code"}, code, 8'h00);
        check({tag, "_code_ext"}, code_ext, 0);
        check({tag, "_code_break"}, code_break, 0);
        check({tag, "_code_valid"}, code_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_key_up"}, key_up, 0);
        check({tag, "_key_down"}, key_down, 0);
        check({tag, "_key_start"}, key_start, 0);
    endtask

    initial begin
        int v0, e0;
        wait_cyc(4);
        check_all_zero("reset");
        rst_n = 1'b1;
        in_reset = 0;
        wait_cyc(20);

        // Space make at a slower bus clock.
        send_frame(8'h29, 0, 200);
        wait_cyc(20);
        check("lit_code_29", code, 8'h29);
        check("lit_key_up_space", key_up, 1);
        $display("frame 29: code=%0h ext=%0b brk=%0b key_up=%0b", code, code_ext, code_break, key_up);

        send_frame(8'h29, 0, HALF);
        send_frame(8'h29, 0, HALF);
        send_frame(8'hF0, 0, HALF);
        send_frame(8'h29, 0, HALF);
        wait_cyc(20);
        check("lit_key_up_space_rel", key_up, 0);

        send_frame(8'hE0, 0, HALF);
        send_frame(8'h75, 0, HALF);
        wait_cyc(20);
        check("lit_up_make_ext", code_ext, 1);
        check("lit_up_make_key", key_up, 1);
        send_frame(8'hE0, 0, HALF);
        send_frame(8'hF0, 0, HALF);
        send_frame(8'h75, 0, HALF);
        wait_cyc(20);
        check("lit_up_break_code", code, 8'h75);
        check("lit_up_break_brk", code_break, 1);
        check("lit_up_break_key", key_up, 0);
        $display("E0 F0 75: code=%0h ext=%0b brk=%0b key_up=%0b", code, code_ext, code_break, key_up);

        // Parity error keeps a pending E0 prefix.
        send_frame(8'hE0, 0, HALF);
        send_frame(8'h72, 1, HALF);
        wait_cyc(20);
        check("lit_key_down_after_bad", key_down, 0);
        send_frame(8'h72, 0, HALF);
        wait_cyc(20);
        check("lit_key_down_make", key_down, 1);
        send_frame(8'hE0, 0, HALF);
        send_frame(8'hF0, 0, HALF);
        send_frame(8'h72, 0, HALF);
        $display("down arrow sequence done: key_down=%0b", key_down);

        // Timeout mid-frame after an E0 prefix.
        send_frame(8'hE0, 0, HALF);
        send_partial(8'h5A, 4);
        begin
            win_t w;
            w.lo = last_fall + TMO;
            w.hi = last_fall + TMO + F + 4;
            err_q.push_back(w);
            m_ext = 0; m_brk = 0;
        end
        wait_cyc(TMO + 300);
        send_frame(8'h5A, 0, HALF);
        wait_cyc(20);
        check("lit_code_5a", code, 8'h5A);
        check("lit_5a_ext", code_ext, 0);
        check("lit_key_start", key_start, 1);
        $display("after timeout: code=%0h ext=%0b key_start=%0b", code, code_ext, key_start);

        // Short glitches on the idle clock line.
        v0 = n_valid_seen;
        e0 = n_err_seen;
        for (int g = 0; g < 5; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(20);
        end
        check("glitch_no_code_valid", n_valid_seen, v0);
        check("glitch_no_frame_err", n_err_seen, e0);
        $display("glitches: code_valid count=%0d frame_err count=%0d", n_valid_seen, n_err_seen);

        // Reset in the middle of a frame that follows an E0 prefix.
        send_frame(8'hE0, 0, HALF);
        send_partial(8'h29, 5);
        in_reset = 1;
        rst_n = 1'b0;
        wait_cyc(1);
        check_all_zero("midreset");
        ev_q.delete();
        err_q.delete();
        m_ext = 0; m_brk = 0; m_up = 0; m_down = 0; m_start = 0;
        wait_cyc(3);
        rst_n = 1'b1;
        in_reset = 0;
        wait_cyc(20);
        send_frame(8'h29, 0, HALF);
        wait_cyc(20);
        check("lit_post_reset_code", code, 8'h29);
        check("lit_post_reset_ext", code_ext, 0);
        check("lit_post_reset_key_up", key_up, 1);
        $display("post reset: code=%0h ext=%0b key_up=%0b", code, code_ext, key_up);

        wait_cyc(F + 10);
        check("events_drained", ev_q.size(), 0);
        check("errors_drained", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
